// File: rtl/bch_chien_search_seq_pkg.sv
// Shared types and elaboration-time GF(2^M) helpers for the sequential Chien search.
package bch_pkg;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   // alpha^k as an M-bit vector (returned in 32 bits), reduced by poly.
   function automatic logic [31:0] gf_alpha_pow(input int k, input int m, input logic [31:0] poly);
      logic [31:0] v;
      v = 32'd1;
      for (int i = 0; i < k; i++) begin
         v = v << 1;
         if (v[m]) v = v ^ poly;
      end
      return v;
   endfunction

   // Exponent of alpha^(-k) expressed as a non-negative exponent below n.
   function automatic int gf_inv_exp(input int k, input int n);
      return (n - (k % n)) % n;
   endfunction

   function automatic logic [31:0] default_prim_poly(input int m);
      case (m)
         3:       return 32'b1011;
         4:       return 32'b10011;
         5:       return 32'b100101;
         6:       return 32'b1000011;
         7:       return 32'b10001001;
         8:       return 32'b100011101;
         default: return 32'b0;
      endcase
   endfunction

endpackage

// File: rtl/bch_chien_search_seq_if.sv
// Start/result bundle between the BM stage (master) and the Chien search (slave).
interface bch_chien_search_seq_if
   import bch_pkg::*;
#(
   parameter int M = 4,
   parameter int T = 2
);
   localparam int N  = (1 << M) - 1;
   localparam int DW = $clog2(T + 1);
   localparam int CW = $clog2(N + 1);

   // start is a request sampled only while idle; done is a one-cycle result strobe.
   logic          start;
   logic [T*M-1:0] lambda;
   logic [DW-1:0] lambda_deg;
   logic          busy;
   logic          done;
   logic [N-1:0]  error_vector;
   logic [CW-1:0] err_count;
   logic          fail;
   state_t        state;

   modport master (
      output start, lambda, lambda_deg,
      input  busy, done, error_vector, err_count, fail, state
   );

   modport slave (
      input  start, lambda, lambda_deg,
      output busy, done, error_vector, err_count, fail, state
   );
endinterface

// File: rtl/bch_chien_search_seq_gf_const_mult.sv
// Multiply an M-bit GF(2^M) element by the constant alpha^EXP; pure XOR network.
module bch_gf_const_mult
   import bch_pkg::*;
#(
   parameter int           M         = 4,
   parameter logic [M:0]   PRIM_POLY = 5'b10011,
   parameter int           EXP       = 0
) (
   input  logic [M-1:0] a,
   output logic [M-1:0] y
);
   logic [M-1:0] cols [M];

   // Column i is alpha^(i+EXP): the image of input basis bit i.
   for (genvar i = 0; i < M; i++) begin : g_col
      localparam logic [31:0] COL = gf_alpha_pow(i + EXP, M, 32'(PRIM_POLY));
      assign cols[i] = a[i] ? COL[M-1:0] : '0;
   end

   always_comb begin
      y = '0;
      for (int i = 0; i < M; i++) y = y ^ cols[i];
   end
endmodule

// File: rtl/bch_chien_search_seq.sv
// Sequential Chien search: evaluates the error locator at alpha^(-i), P positions per cycle.
module bch_chien_search_seq
   import bch_pkg::*;
#(
   parameter int         M         = 4,
   parameter int         T         = 2,
   parameter int         P         = 1,
   parameter logic [M:0] PRIM_POLY = (M + 1)'(default_prim_poly(M))
) (
   input  logic            clk,
   input  logic            rst_n,
   bch_chien_search_seq_if.slave bus
);
   localparam int N  = (1 << M) - 1;
   localparam int DW = $clog2(T + 1);
   localparam int CW = $clog2(N + 1);
   localparam int BW = $clog2(N + P);

   state_t        state, state_nxt;
   logic [BW-1:0] b;
   logic [DW-1:0] deg_q;
   logic [N-1:0]  ev_q, ev_nxt;
   logic [CW-1:0] cnt_q, cnt_add;
   logic          fail_q;
   logic [M-1:0]  r     [T];
   logic [M-1:0]  r_nxt [T];
   logic [M-1:0]  term  [P][T];
   logic [M-1:0]  syn   [P];
   logic [P-1:0]  hit;

   for (genvar p = 0; p < P; p++) begin : g_lane
      for (genvar j = 0; j < T; j++) begin : g_coef
         bch_gf_const_mult #(.M(M), .PRIM_POLY(PRIM_POLY), .EXP(gf_inv_exp((j + 1) * p, N)))
            u_lane (.a(r[j]), .y(term[p][j]));
      end
   end

   for (genvar j = 0; j < T; j++) begin : g_step
      bch_gf_const_mult #(.M(M), .PRIM_POLY(PRIM_POLY), .EXP(gf_inv_exp((j + 1) * P, N)))
         u_step (.a(r[j]), .y(r_nxt[j]));
   end

   // Lanes past position N-1 are masked, which also makes the exit cycle (b >= N) inert.
   always_comb begin
      hit     = '0;
      cnt_add = '0;
      ev_nxt  = ev_q;
      for (int p = 0; p < P; p++) begin
         syn[p] = M'(1);
         for (int j = 0; j < T; j++) syn[p] = syn[p] ^ term[p][j];
         hit[p]  = (syn[p] == '0) && (int'(b) + p < N);
         cnt_add = cnt_add + CW'(hit[p]);
      end
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < P; p++) begin
            if (hit[p] && (int'(b) + p == i)) ev_nxt[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SEARCH;
         SEARCH:  if (int'(b) >= N) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         b      <= '0;
         deg_q  <= '0;
         ev_q   <= '0;
         cnt_q  <= '0;
         fail_q <= 1'b0;
         for (int j = 0; j < T; j++) r[j] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  deg_q  <= bus.lambda_deg;
                  ev_q   <= '0;
                  cnt_q  <= '0;
                  fail_q <= 1'b0;
                  b      <= '0;
                  for (int j = 0; j < T; j++) r[j] <= bus.lambda[j*M +: M];
               end
            end
            SEARCH: begin
               if (int'(b) < N) begin
                  ev_q  <= ev_nxt;
                  cnt_q <= cnt_q + cnt_add;
                  b     <= b + BW'(P);
                  for (int j = 0; j < T; j++) r[j] <= r_nxt[j];
               end else begin
                  fail_q <= (int'(cnt_q) != int'(deg_q));
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);
   assign bus.error_vector = ev_q;
   assign bus.err_count    = cnt_q;
   assign bus.fail         = fail_q;
   assign bus.state        = state;
endmodule

// File: tb/tb_bch_chien_search_seq.sv
// Directed vectors for GF(16), T=2, run on P=1, P=4 and P=15 instances in parallel.
module tb_bch_chien_search_seq;
   import bch_pkg::*;

   typedef struct {
      logic [7:0]  lambda;
      logic [1:0]  deg;
      logic [14:0] ev;
      logic [3:0]  cnt;
      logic        fail;
   } vec_t;

   logic clk;
   logic rst_n;
   logic start;
   logic [7:0] lambda_in;
   logic [1:0] deg_in;

   int n_cmp = 0;
   int n_bad = 0;

   bch_chien_search_seq_if #(.M(4), .T(2)) if1 ();
   bch_chien_search_seq_if #(.M(4), .T(2)) if4 ();
   bch_chien_search_seq_if #(.M(4), .T(2)) if15 ();

   assign if1.start = start;  assign if1.lambda = lambda_in;  assign if1.lambda_deg = deg_in;
   assign if4.start = start;  assign if4.lambda = lambda_in;  assign if4.lambda_deg = deg_in;
   assign if15.start = start; assign if15.lambda = lambda_in; assign if15.lambda_deg = deg_in;

   bch_chien_search_seq #(.M(4), .T(2), .P(1),  .PRIM_POLY(5'b10011)) u_p1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   bch_chien_search_seq #(.M(4), .T(2), .P(4),  .PRIM_POLY(5'b10011)) u_p4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   bch_chien_search_seq #(.M(4), .T(2), .P(15), .PRIM_POLY(5'b10011)) u_p15 (.clk(clk), .rst_n(rst_n), .bus(if15.slave));

   logic [14:0] ev_a   [3];
   logic [3:0]  cnt_a  [3];
   logic        done_a [3];
   logic        busy_a [3];
   logic        fail_a [3];

   assign ev_a[0] = if1.error_vector;  assign cnt_a[0] = if1.err_count;  assign done_a[0] = if1.done;
   assign ev_a[1] = if4.error_vector;  assign cnt_a[1] = if4.err_count;  assign done_a[1] = if4.done;
   assign ev_a[2] = if15.error_vector; assign cnt_a[2] = if15.err_count; assign done_a[2] = if15.done;
   assign busy_a[0] = if1.busy; assign busy_a[1] = if4.busy; assign busy_a[2] = if15.busy;
   assign fail_a[0] = if1.fail; assign fail_a[1] = if4.fail; assign fail_a[2] = if15.fail;

   // done appears B+1 edges after the start edge: B = 15, 4, 1.
   int lat_exp [3] = '{16, 5, 2};

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string name);
      for (int d = 0; d < 3; d++) begin
         chk({name, "_busy"}, d, 32'(busy_a[d]), 32'd0);
         chk({name, "_done"}, d, 32'(done_a[d]), 32'd0);
         chk({name, "_ev"},   d, 32'(ev_a[d]),   32'd0);
         chk({name, "_cnt"},  d, 32'(cnt_a[d]),  32'd0);
         chk({name, "_fail"}, d, 32'(fail_a[d]), 32'd0);
      end
   endtask

   // driver + scoreboard for one search; optionally re-pulses start at cycle inject_at.
   task automatic run_vec(input vec_t v, input int inject_at, input logic [7:0] inj_lambda);
      int          seen  [3];
      int          ndone [3];
      logic [14:0] ev_c  [3];
      logic [3:0]  cnt_c [3];
      logic        fail_c[3];
      for (int d = 0; d < 3; d++) begin
         seen[d] = -1; ndone[d] = 0; ev_c[d] = '0; cnt_c[d] = '0; fail_c[d] = 1'b0;
      end
      lambda_in = v.lambda;
      deg_in    = v.deg;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      lambda_in = 8'hFF;
      deg_in    = 2'd3;
      for (int j = 0; j < 24; j++) begin
         for (int d = 0; d < 3; d++) begin
            if (done_a[d] === 1'b1) begin
               ndone[d]++;
               if (seen[d] < 0) begin
                  seen[d] = j; ev_c[d] = ev_a[d]; cnt_c[d] = cnt_a[d]; fail_c[d] = fail_a[d];
               end
            end
         end
         start = (j == inject_at);
         if (j == inject_at) begin
            lambda_in = inj_lambda;
            deg_in    = 2'd2;
         end
         @(negedge clk);
      end
      start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("latency",    d, 32'(seen[d]),  32'(lat_exp[d]));
         chk("done_pulse", d, 32'(ndone[d]), 32'd1);
         chk("ev",         d, 32'(ev_c[d]),  32'(v.ev));
         chk("cnt",        d, 32'(cnt_c[d]), 32'(v.cnt));
         chk("fail",       d, 32'(fail_c[d]), 32'(v.fail));
         chk("hold_ev",    d, 32'(ev_a[d]),  32'(v.ev));
         chk("hold_fail",  d, 32'(fail_a[d]), 32'(v.fail));
         chk("idle_busy",  d, 32'(busy_a[d]), 32'd0);
      end
   endtask

   vec_t vecs [8];

   initial begin
      // lambda packs lambda2 in [7:4], lambda1 in [3:0]
      vecs[0] = '{8'h00, 2'd0, 15'h0000, 4'd0, 1'b0};  // no roots
      vecs[1] = '{8'h08, 2'd1, 15'h0008, 4'd1, 1'b0};  // 1 + a^3 x
      vecs[2] = '{8'hB2, 2'd2, 15'h0024, 4'd2, 1'b0};  // roots at 2, 5
      vecs[3] = '{8'h10, 2'd2, 15'h0001, 4'd1, 1'b1};  // (1+x)^2, double root
      vecs[4] = '{8'h98, 2'd2, 15'h4001, 4'd2, 1'b0};  // roots at 0 and 14 (last position)
      vecs[5] = '{8'h11, 2'd2, 15'h0420, 4'd2, 1'b0};  // 1+x+x^2: roots at 5, 10
      vecs[6] = '{8'h08, 2'd2, 15'h0008, 4'd1, 1'b1};  // degree claims more roots than found
      vecs[7] = '{8'h00, 2'd1, 15'h0000, 4'd0, 1'b1};  // no roots but degree 1

      rst_n = 1'b0; start = 1'b0; lambda_in = '0; deg_in = '0;
      repeat (3) @(negedge clk);
      chk_idle_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], -1, 8'h00);

      // start re-pulsed while every instance is busy must be ignored
      run_vec(vecs[1], 1, 8'hB2);

      // reset mid-search clears everything, including held results
      lambda_in = 8'h98; deg_in = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_idle_zero("midreset");
      @(negedge clk);
      run_vec(vecs[2], -1, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
